seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the board's 7-segment drive path. The block monitors a time-multiplexed 7-segment bus: a segment byte plus active-low one-hot digit enables. It waits for each pattern to hold stable for a programmable time, then converts it back into a 4-bit digit code with blank and error flags. Per-digit results are held in a register bank, and a one-cycle strobe marks each completed frame. It is used in self-check logic and in loop-back tests of the display driver.

## Interface
- DIGITS, default 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, default 16: number of consecutive identical samples required before a capture (2..255).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SEG  in  8  segment byte, active-low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=DP.
- AN  in  DIGITS  digit enables, active-low, one-hot; bit i selects digit slot i.
- DIGIT_VAL  out  4*DIGITS  decoded code per slot; slot i occupies [4i+3:4i].
- BLANK  out  DIGITS  slot i last captured all segments a..g off.
- DIG_ERR  out  DIGITS  slot i last captured an unrecognised a..g pattern.
- DP  out  DIGITS  slot i last captured with the decimal point lit (SEG[0]==0).
- FRAME_VALID  out  1  one-cycle pulse: every slot has been captured since the previous pulse or reset.

## Operation
- Sample register S holds the {AN, SEG} value from the previous edge. Run counter C saturates at STABLE_CYCLES.
- Each edge compares the current {AN,SEG} against S:
  - If the input differs from S: S <= input, C <= 0.
  - If the input equals S and C < STABLE_CYCLES: C <= C+1.
- Capture event:
  - Condition: input == S, C == STABLE_CYCLES-1, and AN has exactly one bit low.
  - Only one capture fires per stable run, because C saturates afterwards.
  - If AN is all-ones or has more than one bit low, no capture occurs and C still counts.
- Decode of SEG[7:1] (a..g, active-low):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111111 → code 4'hF, BLANK=1, DIG_ERR=0.
  - Any other pattern → code 4'hE, DIG_ERR=1, BLANK=0.
  - A decimal digit sets BLANK=0 and DIG_ERR=0.
  - DP = ~SEG[0], independent of a..g.
- On capture into slot i: write DIGIT_VAL, BLANK, DP and DIG_ERR for slot i, and set seen-mask bit i.
- Re-capturing a slot before the frame completes overwrites its data; the mask is unchanged.
- Frame completion:
  - When a capture makes the mask all-ones, FRAME_VALID=1 at that same edge and the mask clears to 0.
  - The capturing slot's bit is not carried into the next frame.
  - With DIGITS=1, every capture pulses FRAME_VALID.
- Control states, derived from C:
  - WAIT: C < STABLE_CYCLES-1.
  - ARMED: C == STABLE_CYCLES-1; a capture fires if the input is still equal and AN is valid.
  - HELD: C == STABLE_CYCLES; waiting for an input change.
  - Any input change returns the block to WAIT.

## Timing
- Reset values: DIGIT_VAL all 4'hF, BLANK all 1, DIG_ERR 0, DP 0, FRAME_VALID 0, S = {DIGITS{1'b1}, 8'hFF}, C 0, mask 0.
- A pattern first present at edge n is loaded into S at edge n.
  - Slot outputs update at edge n+STABLE_CYCLES, provided the input is unchanged through that edge.
  - The pattern must therefore be held for STABLE_CYCLES+1 sampling edges.
- A change at any edge inside the window restarts the count from that edge. Glitches shorter than the window never capture.
- FRAME_VALID is registered, high for exactly the one cycle after the completing capture edge, and never high on consecutive cycles.
- RST takes priority over capture at the same edge and abandons any partial frame. The first post-reset frame needs all DIGITS slots.
- Outputs are constant between captures. No combinational path exists from inputs to outputs.

## Test plan
All cases use DIGITS=4, STABLE_CYCLES=4.
- Reset: assert RST for 2 cycles with random inputs → DIGIT_VAL=16'hFFFF, BLANK=4'hF, DIG_ERR=0, DP=0, FRAME_VALID=0.
- Window edge, 5 edges: AN=4'b1110, SEG=8'b00100101 held 5 edges → slot0=2, BLANK[0]=0.
- Window edge, 4 edges: the same pattern held only 4 edges, then SEG=8'hFF → slot0 unchanged.
- Full frame: AN 1110/1101/1011/0111 with SEG codes for 1,2,3,4, 8 cycles each → DIGIT_VAL=16'h4321, exactly one FRAME_VALID pulse, one cycle after the 4th capture edge.
- Flags, slot 1: SEG=8'b00000000 on slot 1 → code 8, DP[1]=1.
- Flags, slot 2: SEG=8'b01101101 on slot 2 → code E, DIG_ERR[2]=1.
- Flags, slot 3: SEG=8'hFF on slot 3 → code F, BLANK[3]=1.
- Invalid enables: AN=4'b1100 or 4'b1111 held 10 cycles → no output change.
- Glitch: SEG toggles one bit every 3 cycles → no capture ever.
- Reset mid-frame: capture slots 0 and 1, pulse RST, then capture slots 2 and 3 → no FRAME_VALID until slots 0 and 1 are captured again.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus. Each {AN, SEG} pattern must stay stable for a
// programmable window before it is decoded into a per-slot register bank with frame strobes.
module seg_scan_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            SEG,
    input  logic [DIGITS-1:0]     AN,
    output logic [4*DIGITS-1:0]   DIGIT_VAL,
    output logic [DIGITS-1:0]     BLANK,
    output logic [DIGITS-1:0]     DIG_ERR,
    output logic [DIGITS-1:0]     DP,
    output logic                  FRAME_VALID
);

    localparam int unsigned SW = DIGITS + 8;
    localparam logic [7:0] CntHeld  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CntArmed = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StWait, StArmed, StHeld} state_e;

    logic [SW-1:0]         sample_q, sample_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [4*DIGITS-1:0]   val_q, val_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic [DIGITS-1:0]     err_q, err_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  fv_q, fv_d;

    logic [SW-1:0]         in_word;
    logic                  same;
    state_e                state;
    logic [3:0]            low_cnt;
    logic                  an_valid;
    logic [DIGITS-1:0]     slot_oh;
    logic                  capture;
    logic [3:0]            code;
    logic                  code_blank;
    logic                  code_err;
    logic [DIGITS-1:0]     mask_next;

    assign in_word = {AN, SEG};
    assign same    = (in_word == sample_q);
    assign slot_oh = ~AN;

    // Control state is a pure function of the run counter; no separate state register needed.
    always_comb begin
        state = StWait;
        if (cnt_q == CntHeld) begin
            state = StHeld;
        end else if (cnt_q == CntArmed) begin
            state = StArmed;
        end
    end

    always_comb begin
        low_cnt = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            low_cnt = low_cnt + {3'b000, slot_oh[i]};
        end
        an_valid = (low_cnt == 4'd1);
    end

    assign capture = same && (state == StArmed) && an_valid;

    always_comb begin
        code       = 4'hE;
        code_blank = 1'b0;
        code_err   = 1'b0;
        case (SEG[7:1])
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: begin
                code       = 4'hF;
                code_blank = 1'b1;
            end
            default: begin
                code     = 4'hE;
                code_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        if (!same) begin
            sample_d = in_word;
            cnt_d    = 8'd0;
        end else if (state != StHeld) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        val_d     = val_q;
        blank_d   = blank_q;
        err_d     = err_q;
        dp_d      = dp_q;
        mask_d    = mask_q;
        fv_d      = 1'b0;
        mask_next = mask_q | slot_oh;
        if (capture) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (slot_oh[i]) begin
                    val_d[4*i +: 4] = code;
                    blank_d[i]      = code_blank;
                    err_d[i]        = code_err;
                    dp_d[i]         = ~SEG[0];
                end
            end
            // Completing slot starts the next frame with an empty mask.
            if (&mask_next) begin
                fv_d   = 1'b1;
                mask_d = '0;
            end else begin
                mask_d = mask_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_q <= {{DIGITS{1'b1}}, 8'hFF};
            cnt_q    <= 8'd0;
            mask_q   <= '0;
            val_q    <= {DIGITS{4'hF}};
            blank_q  <= '1;
            err_q    <= '0;
            dp_q     <= '0;
            fv_q     <= 1'b0;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            val_q    <= val_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            dp_q     <= dp_d;
            fv_q     <= fv_d;
        end
    end

    assign DIGIT_VAL   = val_q;
    assign BLANK       = blank_q;
    assign DIG_ERR     = err_q;
    assign DP          = dp_q;
    assign FRAME_VALID = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed cases plus random bus traffic, every cycle compared
// against a run-length reference model of the stable-window capture and frame tracking.
module tb_seg_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digit_val;
    logic [3:0]  blank;
    logic [3:0]  dig_err;
    logic [3:0]  dp;
    logic        frame_valid;

    int chk_count  = 0;
    int fail_count = 0;
    int fv_cnt     = 0;
    int fv_idx     = -1;
    int tick_idx   = 0;

    // Reference model state
    logic [11:0] m_last;
    int          m_run;
    logic [15:0] m_val;
    logic [3:0]  m_blank, m_err, m_dp;
    logic [3:0]  m_seen;
    logic        m_fv;

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    seg_scan_decoder #(
        .DIGITS        (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .SEG         (seg),
        .AN          (an),
        .DIGIT_VAL   (digit_val),
        .BLANK       (blank),
        .DIG_ERR     (dig_err),
        .DP          (dp),
        .FRAME_VALID (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_decode(input logic [6:0] p, output logic [3:0] c, output logic b,
                            output logic e);
        c = 4'hE;
        b = 1'b0;
        e = 1'b1;
        if (p == 7'h7F) begin
            c = 4'hF;
            b = 1'b1;
            e = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (pat[k] == p) begin
                c = 4'(k);
                e = 1'b0;
            end
        end
    endtask

    // A pattern captures on the edge where it has been seen on SC+1 consecutive edges;
    // the reset edge counts as the first edge of the all-ones pattern.
    task automatic model_edge(input logic r, input logic [3:0] a, input logic [7:0] s);
        logic [3:0] c;
        logic       b, e;
        int         slot;
        int         lows;
        m_fv = 1'b0;
        if (r) begin
            m_last  = 12'hFFF;
            m_run   = 1;
            m_val   = 16'hFFFF;
            m_blank = 4'hF;
            m_err   = 4'h0;
            m_dp    = 4'h0;
            m_seen  = 4'h0;
            return;
        end
        if ({a, s} == m_last) begin
            m_run++;
        end else begin
            m_last = {a, s};
            m_run  = 1;
        end
        lows = 0;
        slot = 0;
        for (int k = 0; k < 4; k++) begin
            if (!a[k]) begin
                lows++;
                slot = k;
            end
        end
        if (m_run == SC + 1 && lows == 1) begin
            m_decode(s[7:1], c, b, e);
            m_val[4*slot +: 4] = c;
            m_blank[slot]      = b;
            m_err[slot]        = e;
            m_dp[slot]         = ~s[0];
            m_seen[slot]       = 1'b1;
            if (m_seen == 4'hF) begin
                m_fv   = 1'b1;
                m_seen = 4'h0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] a, input logic [7:0] s);
        rst = r;
        an  = a;
        seg = s;
        @(posedge clk);
        model_edge(r, a, s);
        #1;
        check("digit_val", 64'(digit_val), 64'(m_val));
        check("blank", 64'(blank), 64'(m_blank));
        check("dig_err", 64'(dig_err), 64'(m_err));
        check("dp", 64'(dp), 64'(m_dp));
        check("frame_valid", 64'(frame_valid), 64'(m_fv));
        if (frame_valid) begin
            fv_cnt++;
            fv_idx = tick_idx;
        end
        tick_idx++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        tick_idx = 0;
        fv_idx   = -1;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, a, s);
        end
    endtask

    initial begin
        logic [7:0] gs;
        logic [3:0] ra;
        logic [7:0] rs;
        int         sel;

        // Reset with random bus contents
        tick(1'b1, 4'($urandom), 8'($urandom));
        tick(1'b1, 4'($urandom), 8'($urandom));
        check("rst_val", 64'(digit_val), 64'h0000_0000_0000_FFFF);
        check("rst_blank", 64'(blank), 64'hF);
        check("rst_err", 64'(dig_err), 64'h0);
        check("rst_dp", 64'(dp), 64'h0);
        check("rst_fv", 64'(frame_valid), 64'h0);

        // Window boundary: 5 edges captures, 4 edges does not
        hold(4'b1110, 8'b00100101, 5);
        check("win5_slot0", 64'(digit_val[3:0]), 64'h2);
        check("win5_blank0", 64'(blank[0]), 64'h0);
        tick(1'b1, 4'hF, 8'hFF);
        hold(4'b1110, 8'b00100101, 4);
        hold(4'b1110, 8'hFF, 3);
        check("win4_slot0", 64'(digit_val[3:0]), 64'hF);
        check("win4_blank0", 64'(blank[0]), 64'h1);

        // Full frame
        tick(1'b1, 4'hF, 8'hFF);
        fv_cnt = 0;
        hold(4'b1110, 8'b10011111, 8);
        hold(4'b1101, 8'b00100101, 8);
        hold(4'b1011, 8'b00001101, 8);
        hold(4'b0111, 8'b10011001, 8);
        check("frame_val", 64'(digit_val), 64'h4321);
        check("frame_pulses", 64'(fv_cnt), 64'd1);
        check("frame_pulse_pos", 64'(fv_idx), 64'd4);

        // Flags
        hold(4'b1101, 8'b00000000, 6);
        check("slot1_code", 64'(digit_val[7:4]), 64'h8);
        check("slot1_dp", 64'(dp[1]), 64'h1);
        hold(4'b1011, 8'b01101101, 6);
        check("slot2_code", 64'(digit_val[11:8]), 64'hE);
        check("slot2_err", 64'(dig_err[2]), 64'h1);
        hold(4'b0111, 8'hFF, 6);
        check("slot3_code", 64'(digit_val[15:12]), 64'hF);
        check("slot3_blank", 64'(blank[3]), 64'h1);

        // Invalid enables
        hold(4'b1100, 8'b00100101, 10);
        hold(4'b1111, 8'b00100101, 10);
        check("inval_val", 64'(digit_val), 64'hFE81);
        check("inval_flags", 64'({blank, dig_err, dp}), 64'h842);

        // Glitching segment bit never captures
        fv_cnt = 0;
        gs = 8'b00100101;
        for (int i = 0; i < 8; i++) begin
            hold(4'b1110, gs, 3);
            gs = gs ^ 8'h02;
        end
        check("glitch_val", 64'(digit_val), 64'hFE81);
        check("glitch_fv", 64'(fv_cnt), 64'd0);

        // Reset mid-frame abandons captured slots
        tick(1'b1, 4'hF, 8'hFF);
        hold(4'b1110, 8'b10011111, 6);
        hold(4'b1101, 8'b00100101, 6);
        tick(1'b1, 4'hF, 8'hFF);
        fv_cnt = 0;
        hold(4'b1011, 8'b00001101, 6);
        hold(4'b0111, 8'b10011001, 6);
        check("midrst_nofv", 64'(fv_cnt), 64'd0);
        hold(4'b1110, 8'b10011111, 6);
        hold(4'b1101, 8'b00100101, 6);
        check("midrst_fv", 64'(fv_cnt), 64'd1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 5));
            if (sel < 4) ra = ~(4'b0001 << sel);
            else if (sel == 4) ra = 4'hF;
            else ra = 4'($urandom);
            if ($urandom_range(0, 1) == 0) rs = {pat[$urandom_range(0, 9)], 1'($urandom)};
            else rs = 8'($urandom);
            if ($urandom_range(0, 19) == 0) tick(1'b1, ra, rs);
            else hold(ra, rs, int'($urandom_range(1, 8)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
        $finish;
    end

endmodule
